// File: rtl/pau_wb_buffer.sv
// In-order result buffer between the posit arithmetic unit and the shared FP/posit writeback port.
// Stores {trans_id, result} pairs in a circular array; a flush drops every pending result.
module pau_wb_buffer #(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [TRANS_ID_BITS-1:0]   in_trans_id_i,
    input  logic [XLEN-1:0]            in_result_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [XLEN-1:0]            wb_result_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [TRANS_ID_BITS-1:0] id_mem_r  [DEPTH];
    logic [XLEN-1:0]          res_mem_r [DEPTH];
    logic [PW-1:0]            wptr_r;
    logic [PW-1:0]            rptr_r;
    logic [CW-1:0]            count_r;
    logic [CW-1:0]            count_next_s;
    logic                     push_s;
    logic                     pop_s;

    // Ready and valid come only from the occupancy register, so there is no
    // combinational path from wb_ready_i back to in_ready_o.
    assign in_ready_o    = (count_r != FULL_CNT);
    assign wb_valid_o    = (count_r != {CW{1'b0}});
    assign push_s        = in_valid_i && in_ready_o && !flush_i;
    assign pop_s         = wb_valid_o && wb_ready_i && !flush_i;
    assign wb_trans_id_o = id_mem_r[rptr_r];
    assign wb_result_o   = res_mem_r[rptr_r];
    assign count_o       = count_r;

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Entry storage; flush leaves contents in place, only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_mem_r[i]  <= {TRANS_ID_BITS{1'b0}};
                res_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            id_mem_r[wptr_r]  <= in_trans_id_i;
            res_mem_r[wptr_r] <= in_result_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush_i) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            count_r <= count_next_s;
        end
    end

    pau_wb_buffer_chk #(
        .DEPTH         (DEPTH),
        .TRANS_ID_BITS (TRANS_ID_BITS),
        .XLEN          (XLEN)
    ) u_chk (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .flush       (flush_i),
        .count       (count_r),
        .wb_valid    (wb_valid_o),
        .wb_ready    (wb_ready_i),
        .wb_trans_id (wb_trans_id_o),
        .wb_result   (wb_result_o)
    );

endmodule

// Invariant checker for pau_wb_buffer: occupancy bound, no empty pop, held head data.
module pau_wb_buffer_chk #(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64
) (
    input logic                      clk,
    input logic                      rst_n,
    input logic                      flush,
    input logic [$clog2(DEPTH):0]    count,
    input logic                      wb_valid,
    input logic                      wb_ready,
    input logic [TRANS_ID_BITS-1:0]  wb_trans_id,
    input logic [XLEN-1:0]           wb_result
);

    localparam int CW = $clog2(DEPTH) + 1;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

    a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid && wb_ready) |-> (count != {CW{1'b0}}));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_valid && !wb_ready && !flush) |=> ($stable(wb_trans_id) && $stable(wb_result)));

endmodule

// File: tb/tb_pau_wb_buffer.sv
// Directed self-checking bench for pau_wb_buffer: reset, single result, fill/full,
// simultaneous push/pop with pointer wrap, flush, and asynchronous reset mid-stream.
module tb_pau_wb_buffer;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  in_trans_id_i;
    logic [63:0] in_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [2:0]  wb_trans_id_o;
    logic [63:0] wb_result_o;
    logic [2:0]  count_o;

    int tests;
    int fails;

    localparam logic [63:0] BASE = 64'hC0DE_0000_0000_0000;

    pau_wb_buffer #(.DEPTH(4), .TRANS_ID_BITS(3), .XLEN(64)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_trans_id_i (in_trans_id_i),
        .in_result_i   (in_result_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_trans_id_o (wb_trans_id_o),
        .wb_result_o   (wb_result_o),
        .count_o       (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic test_reset;
        rst_ni = 1'b0;
        #1;
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", wb_valid_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", in_ready_o); end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        tests++; if (wb_trans_id_o !== 3'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", wb_trans_id_o); end
        tests++; if (wb_result_o !== 64'd0) begin fails++; $display("FAIL reset_result: got %0h expected 0", wb_result_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL idle_valid: got %0b expected 0", wb_valid_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL idle_ready: got %0b expected 1", in_ready_o); end
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL idle_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_single;
        in_valid_i    = 1'b1;
        in_trans_id_i = 3'd3;
        in_result_i   = 64'h4000_0000_0000_0000;
        wb_ready_i    = 1'b1;
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL single_no_fallthrough: got %0b expected 0", wb_valid_o); end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        tests++; if (wb_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b expected 1", wb_valid_o); end
        tests++; if (wb_trans_id_o !== 3'd3) begin fails++; $display("FAIL single_id: got %0d expected 3", wb_trans_id_o); end
        tests++; if (wb_result_o !== 64'h4000_0000_0000_0000) begin fails++; $display("FAIL single_result: got %0h expected 4000000000000000", wb_result_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL single_count1: got %0d expected 1", count_o); end
        @(negedge clk_i);
        wb_ready_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL single_count0: got %0d expected 0", count_o); end
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL single_empty: got %0b expected 0", wb_valid_o); end
    endtask

    task automatic test_fill;
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i    = 1'b1;
            in_trans_id_i = 3'(i);
            in_result_i   = 64'h100 + 64'(i);
            @(negedge clk_i);
        end
        tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL fill_not_ready: got %0b expected 0", in_ready_o); end
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", count_o); end
        in_trans_id_i = 3'd4;
        in_result_i   = 64'h104;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL full_ignore_count: got %0d expected 4", count_o); end
        tests++; if (wb_trans_id_o !== 3'd0) begin fails++; $display("FAIL full_head_id: got %0d expected 0", wb_trans_id_o); end
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (wb_valid_o !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d]: got %0b expected 1", i, wb_valid_o); end
            tests++; if (wb_trans_id_o !== 3'(i)) begin fails++; $display("FAIL drain_id[%0d]: got %0d expected %0d", i, wb_trans_id_o, i); end
            tests++; if (wb_result_o !== 64'h100 + 64'(i)) begin fails++; $display("FAIL drain_result[%0d]: got %0h expected %0h", i, wb_result_o, 64'h100 + 64'(i)); end
            @(negedge clk_i);
            if (i == 0) begin
                tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL drain_ready_after_pop: got %0b expected 1", in_ready_o); end
            end
        end
        wb_ready_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d expected 0", count_o); end
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL drain_empty: got %0b expected 0", wb_valid_o); end
    endtask

    task automatic test_back_to_back;
        int k;
        int exp_pop;
        k = 0;
        exp_pop = 0;
        wb_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i    = 1'b1;
            in_trans_id_i = 3'(k);
            in_result_i   = BASE + 64'(k);
            k++;
            @(negedge clk_i);
        end
        tests++; if (count_o !== 3'd2) begin fails++; $display("FAIL b2b_prefill_count: got %0d expected 2", count_o); end
        for (int c = 0; c < 8; c++) begin
            in_valid_i    = 1'b1;
            in_trans_id_i = 3'(k);
            in_result_i   = BASE + 64'(k);
            wb_ready_i    = 1'b1;
            tests++; if (wb_trans_id_o !== 3'(exp_pop)) begin fails++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", c, wb_trans_id_o, exp_pop % 8); end
            tests++; if (wb_result_o !== BASE + 64'(exp_pop)) begin fails++; $display("FAIL b2b_result[%0d]: got %0h expected %0h", c, wb_result_o, BASE + 64'(exp_pop)); end
            @(negedge clk_i);
            k++;
            exp_pop++;
            tests++; if (count_o !== 3'd2) begin fails++; $display("FAIL b2b_count[%0d]: got %0d expected 2", c, count_o); end
        end
        in_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++; if (wb_trans_id_o !== 3'(exp_pop)) begin fails++; $display("FAIL b2b_tail_id[%0d]: got %0d expected %0d", i, wb_trans_id_o, exp_pop % 8); end
            tests++; if (wb_result_o !== BASE + 64'(exp_pop)) begin fails++; $display("FAIL b2b_tail_result[%0d]: got %0h expected %0h", i, wb_result_o, BASE + 64'(exp_pop)); end
            @(negedge clk_i);
            exp_pop++;
        end
        wb_ready_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL b2b_final_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_flush;
        wb_ready_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            in_valid_i    = 1'b1;
            in_trans_id_i = 3'(i);
            in_result_i   = 64'h200 + 64'(i);
            @(negedge clk_i);
        end
        tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL flush_pre_count: got %0d expected 3", count_o); end
        in_trans_id_i = 3'd7;
        in_result_i   = 64'h207;
        flush_i       = 1'b1;
        @(negedge clk_i);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0b expected 0", wb_valid_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready: got %0b expected 1", in_ready_o); end
        in_valid_i    = 1'b1;
        in_trans_id_i = 3'd5;
        in_result_i   = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL post_flush_count: got %0d expected 1", count_o); end
        tests++; if (wb_trans_id_o !== 3'd5) begin fails++; $display("FAIL post_flush_id: got %0d expected 5", wb_trans_id_o); end
        tests++; if (wb_result_o !== 64'h5555_AAAA_5555_AAAA) begin fails++; $display("FAIL post_flush_result: got %0h expected 5555aaaa5555aaaa", wb_result_o); end
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        wb_ready_i = 1'b0;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL post_flush_pop: got %0d expected 0", count_o); end
    endtask

    task automatic test_async_reset;
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i    = 1'b1;
            in_trans_id_i = 3'(i + 4);
            in_result_i   = 64'h300 + 64'(i);
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL ar_pre_count: got %0d expected 4", count_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL ar_count: got %0d expected 0", count_o); end
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL ar_valid: got %0b expected 0", wb_valid_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL ar_ready: got %0b expected 1", in_ready_o); end
        tests++; if (wb_trans_id_o !== 3'd0) begin fails++; $display("FAIL ar_id: got %0d expected 0", wb_trans_id_o); end
        tests++; if (wb_result_o !== 64'd0) begin fails++; $display("FAIL ar_result: got %0h expected 0", wb_result_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        in_valid_i    = 1'b1;
        in_trans_id_i = 3'd6;
        in_result_i   = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        tests++; if (wb_trans_id_o !== 3'd6) begin fails++; $display("FAIL ar_resume_id: got %0d expected 6", wb_trans_id_o); end
        tests++; if (wb_result_o !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL ar_resume_result: got %0h expected 0123456789abcdef", wb_result_o); end
        tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL ar_resume_count: got %0d expected 1", count_o); end
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        wb_ready_i = 1'b0;
        tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL ar_resume_empty: got %0b expected 0", wb_valid_o); end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        in_valid_i    = 1'b0;
        in_trans_id_i = 3'd0;
        in_result_i   = 64'd0;
        wb_ready_i    = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
